// File: rtl/riscv_dmem_arbiter.sv
// Two-master arbiter in front of the dcache port: round-robin grant that locks onto a
// presented-but-not-taken request, with an in-order owner FIFO that steers responses back.
module riscv_dmem_arbiter #(
    parameter int OUTSTANDING_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_wr_i,
    input  logic        m0_rd_i,
    input  logic [3:0]  m0_wr_i,
    input  logic        m0_cacheable_i,
    input  logic [10:0] m0_req_tag_i,
    input  logic        m0_invalidate_i,
    input  logic        m0_flush_i,
    output logic        m0_accept_o,
    output logic        m0_ack_o,
    output logic        m0_error_o,
    output logic [31:0] m0_data_rd_o,
    output logic [10:0] m0_resp_tag_o,

    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_wr_i,
    input  logic        m1_rd_i,
    input  logic [3:0]  m1_wr_i,
    input  logic        m1_cacheable_i,
    input  logic [10:0] m1_req_tag_i,
    input  logic        m1_invalidate_i,
    input  logic        m1_flush_i,
    output logic        m1_accept_o,
    output logic        m1_ack_o,
    output logic        m1_error_o,
    output logic [31:0] m1_data_rd_o,
    output logic [10:0] m1_resp_tag_o,

    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_wr_o,
    output logic        mem_rd_o,
    output logic [3:0]  mem_wr_o,
    output logic        mem_cacheable_o,
    output logic [10:0] mem_req_tag_o,
    output logic        mem_invalidate_o,
    output logic        mem_flush_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic        mem_error_i,
    input  logic [31:0] mem_data_rd_i,
    input  logic [10:0] mem_resp_tag_i,

    output logic        err_orphan_o
);

    localparam int PTR_W = (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(OUTSTANDING_DEPTH);

    logic [31:0] addr_arr  [2];
    logic [31:0] wdata_arr [2];
    logic        rd_arr    [2];
    logic [3:0]  wr_arr    [2];
    logic        cache_arr [2];
    logic [10:0] tag_arr   [2];
    logic        inv_arr   [2];
    logic        flush_arr [2];
    logic [1:0]  req_vec;

    assign addr_arr[0]  = m0_addr_i;       assign addr_arr[1]  = m1_addr_i;
    assign wdata_arr[0] = m0_data_wr_i;    assign wdata_arr[1] = m1_data_wr_i;
    assign rd_arr[0]    = m0_rd_i;         assign rd_arr[1]    = m1_rd_i;
    assign wr_arr[0]    = m0_wr_i;         assign wr_arr[1]    = m1_wr_i;
    assign cache_arr[0] = m0_cacheable_i;  assign cache_arr[1] = m1_cacheable_i;
    assign tag_arr[0]   = m0_req_tag_i;    assign tag_arr[1]   = m1_req_tag_i;
    assign inv_arr[0]   = m0_invalidate_i; assign inv_arr[1]   = m1_invalidate_i;
    assign flush_arr[0] = m0_flush_i;      assign flush_arr[1] = m1_flush_i;

    logic             lock_vld_reg;
    logic             lock_id_reg;
    logic             rr_reg;
    logic             orphan_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             fifo_mem [OUTSTANDING_DEPTH];

    logic grant_vld;
    logic grant_id;
    logic fifo_full;
    logic fifo_empty;
    logic strobe_en;
    logic take;
    logic pop;
    logic orphan;
    logic head_id;

    logic [1:0]  accept_vec;
    logic [1:0]  ack_vec;
    logic [1:0]  err_vec;
    logic [31:0] rdata_vec [2];
    logic [10:0] rtag_vec  [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign req_vec[gi]    = rd_arr[gi] | (|wr_arr[gi]) | inv_arr[gi] | flush_arr[gi];
            assign accept_vec[gi] = take & (grant_id == 1'(gi));
            assign ack_vec[gi]    = pop & (head_id == 1'(gi));
            assign err_vec[gi]    = ack_vec[gi] & mem_error_i;
            assign rdata_vec[gi]  = ack_vec[gi] ? mem_data_rd_i : 32'd0;
            assign rtag_vec[gi]   = ack_vec[gi] ? mem_resp_tag_i : 11'd0;
        end
    endgenerate

    // A presented request holds the grant until the dcache takes it.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (lock_vld_reg) begin
            grant_vld = 1'b1;
            grant_id  = lock_id_reg;
        end else if (&req_vec) begin
            grant_vld = 1'b1;
            grant_id  = rr_reg;
        end else if (req_vec[0]) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (req_vec[1]) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    assign fifo_full  = (count_reg == FULL_COUNT);
    assign fifo_empty = (count_reg == '0);
    assign strobe_en  = grant_vld & ~fifo_full & rst_ni;
    assign take       = strobe_en & mem_accept_i;
    assign pop        = rst_ni & mem_ack_i & ~fifo_empty;
    assign orphan     = mem_ack_i & fifo_empty;
    assign head_id    = fifo_mem[rd_ptr_reg];

    assign mem_addr_o       = grant_vld ? addr_arr[grant_id]  : 32'd0;
    assign mem_data_wr_o    = grant_vld ? wdata_arr[grant_id] : 32'd0;
    assign mem_cacheable_o  = grant_vld & cache_arr[grant_id];
    assign mem_req_tag_o    = grant_vld ? tag_arr[grant_id]   : 11'd0;
    assign mem_rd_o         = strobe_en & rd_arr[grant_id];
    assign mem_wr_o         = strobe_en ? wr_arr[grant_id]    : 4'd0;
    assign mem_invalidate_o = strobe_en & inv_arr[grant_id];
    assign mem_flush_o      = strobe_en & flush_arr[grant_id];

    assign m0_accept_o   = accept_vec[0];
    assign m0_ack_o      = ack_vec[0];
    assign m0_error_o    = err_vec[0];
    assign m0_data_rd_o  = rdata_vec[0];
    assign m0_resp_tag_o = rtag_vec[0];
    assign m1_accept_o   = accept_vec[1];
    assign m1_ack_o      = ack_vec[1];
    assign m1_error_o    = err_vec[1];
    assign m1_data_rd_o  = rdata_vec[1];
    assign m1_resp_tag_o = rtag_vec[1];
    assign err_orphan_o  = orphan_reg;

    always_comb begin
        count_next = count_reg;
        if (take && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!take && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rr_reg       <= 1'b0;
            lock_vld_reg <= 1'b0;
            lock_id_reg  <= 1'b0;
            orphan_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (take) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (take) begin
                lock_vld_reg <= 1'b0;
                rr_reg       <= ~grant_id;
            end else if (grant_vld) begin
                lock_vld_reg <= 1'b1;
                lock_id_reg  <= grant_id;
            end
            if (orphan) begin
                orphan_reg <= 1'b1;
            end
        end
    end

    // Owner storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (take) begin
            fifo_mem[wr_ptr_reg] <= grant_id;
        end
    end

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Bench for riscv_dmem_arbiter: directed scenarios plus random traffic, all cycles
// compared against a queue-based model of grant, take and response routing.
module tb_riscv_dmem_arbiter;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] m0_addr_i, m0_data_wr_i, m1_addr_i, m1_data_wr_i;
    logic        m0_rd_i, m1_rd_i, m0_cacheable_i, m1_cacheable_i;
    logic [3:0]  m0_wr_i, m1_wr_i;
    logic [10:0] m0_req_tag_i, m1_req_tag_i;
    logic        m0_invalidate_i, m0_flush_i, m1_invalidate_i, m1_flush_i;
    logic        m0_accept_o, m0_ack_o, m0_error_o, m1_accept_o, m1_ack_o, m1_error_o;
    logic [31:0] m0_data_rd_o, m1_data_rd_o;
    logic [10:0] m0_resp_tag_o, m1_resp_tag_o;
    logic [31:0] mem_addr_o, mem_data_wr_o, mem_data_rd_i;
    logic        mem_rd_o, mem_cacheable_o, mem_invalidate_o, mem_flush_o;
    logic [3:0]  mem_wr_o;
    logic [10:0] mem_req_tag_o, mem_resp_tag_i;
    logic        mem_accept_i, mem_ack_i, mem_error_i, err_orphan_o;

    riscv_dmem_arbiter #(.OUTSTANDING_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_addr_i(m0_addr_i), .m0_data_wr_i(m0_data_wr_i), .m0_rd_i(m0_rd_i), .m0_wr_i(m0_wr_i),
        .m0_cacheable_i(m0_cacheable_i), .m0_req_tag_i(m0_req_tag_i),
        .m0_invalidate_i(m0_invalidate_i), .m0_flush_i(m0_flush_i),
        .m0_accept_o(m0_accept_o), .m0_ack_o(m0_ack_o), .m0_error_o(m0_error_o),
        .m0_data_rd_o(m0_data_rd_o), .m0_resp_tag_o(m0_resp_tag_o),
        .m1_addr_i(m1_addr_i), .m1_data_wr_i(m1_data_wr_i), .m1_rd_i(m1_rd_i), .m1_wr_i(m1_wr_i),
        .m1_cacheable_i(m1_cacheable_i), .m1_req_tag_i(m1_req_tag_i),
        .m1_invalidate_i(m1_invalidate_i), .m1_flush_i(m1_flush_i),
        .m1_accept_o(m1_accept_o), .m1_ack_o(m1_ack_o), .m1_error_o(m1_error_o),
        .m1_data_rd_o(m1_data_rd_o), .m1_resp_tag_o(m1_resp_tag_o),
        .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o), .mem_rd_o(mem_rd_o),
        .mem_wr_o(mem_wr_o), .mem_cacheable_o(mem_cacheable_o), .mem_req_tag_o(mem_req_tag_o),
        .mem_invalidate_o(mem_invalidate_o), .mem_flush_o(mem_flush_o),
        .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i), .mem_error_i(mem_error_i),
        .mem_data_rd_i(mem_data_rd_i), .mem_resp_tag_i(mem_resp_tag_i),
        .err_orphan_o(err_orphan_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pending request per requester, held until the model sees it accepted
    logic        p_act  [2];
    logic        p_rd   [2];
    logic [3:0]  p_wr   [2];
    logic        p_inv  [2];
    logic        p_fl   [2];
    logic        p_cach [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_data [2];
    logic [10:0] p_tag  [2];
    bit          auto_refill [2];

    // Reference model state
    int q[$];
    int lock_m  = -1;
    int rr_m    = 0;
    bit orphan_m = 1'b0;

    // Observations captured during the last cycle
    logic [1:0]  snap_acc, snap_ack;
    logic [6:0]  snap_strb;
    logic [31:0] snap_addr, snap_m0_data;
    logic [10:0] snap_m0_tag;
    logic        snap_m1_err, snap_orphan;

    task automatic arm(input int i, input logic rd, input logic [3:0] wr, input logic inv,
                       input logic fl, input logic [31:0] addr, input logic [10:0] tag);
        p_act[i]  = 1'b1;
        p_rd[i]   = rd;
        p_wr[i]   = wr;
        p_inv[i]  = inv;
        p_fl[i]   = fl;
        p_addr[i] = addr;
        p_tag[i]  = tag;
        p_data[i] = $urandom;
        p_cach[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic arm_random(input int i);
        int kind;
        logic [31:0] a;
        logic [10:0] t;
        kind = $urandom_range(0, 3);
        a = $urandom;
        t = 11'($urandom);
        case (kind)
            0:       arm(i, 1'b1, 4'd0, 1'b0, 1'b0, a, t);
            1:       arm(i, 1'b0, 4'($urandom_range(1, 15)), 1'b0, 1'b0, a, t);
            2:       arm(i, 1'b0, 4'd0, 1'b1, 1'b0, a, t);
            default: arm(i, 1'b0, 4'd0, 1'b0, 1'b1, a, t);
        endcase
    endtask

    task automatic drive_inputs();
        m0_rd_i         = p_act[0] & p_rd[0];
        m0_wr_i         = p_act[0] ? p_wr[0] : 4'd0;
        m0_invalidate_i = p_act[0] & p_inv[0];
        m0_flush_i      = p_act[0] & p_fl[0];
        m0_addr_i       = p_addr[0];
        m0_data_wr_i    = p_data[0];
        m0_cacheable_i  = p_cach[0];
        m0_req_tag_i    = p_tag[0];
        m1_rd_i         = p_act[1] & p_rd[1];
        m1_wr_i         = p_act[1] ? p_wr[1] : 4'd0;
        m1_invalidate_i = p_act[1] & p_inv[1];
        m1_flush_i      = p_act[1] & p_fl[1];
        m1_addr_i       = p_addr[1];
        m1_data_wr_i    = p_data[1];
        m1_cacheable_i  = p_cach[1];
        m1_req_tag_i    = p_tag[1];
    endtask

    task automatic snapshot();
        snap_acc     = {m1_accept_o, m0_accept_o};
        snap_ack     = {m1_ack_o, m0_ack_o};
        snap_strb    = {mem_rd_o, mem_wr_o, mem_invalidate_o, mem_flush_o};
        snap_addr    = mem_addr_o;
        snap_m0_data = m0_data_rd_o;
        snap_m0_tag  = m0_resp_tag_o;
        snap_m1_err  = m1_error_o;
        snap_orphan  = err_orphan_o;
    endtask

    // One clock cycle: drive, compare against the model, clock, then advance the model.
    task automatic do_cycle(input logic acc, input logic ack, input logic err,
                            input logic [31:0] rdata, input logic [10:0] rtag);
        bit          full, take;
        int          gid, owner;
        logic [6:0]  exp_strb;
        logic [63:0] exp_fields;
        logic [11:0] exp_ct;
        logic [1:0]  exp_acc;
        logic [12:0] exp_resp [2];
        logic [31:0] exp_rdata [2];

        mem_accept_i   = acc;
        mem_ack_i      = ack;
        mem_error_i    = err;
        mem_data_rd_i  = rdata;
        mem_resp_tag_i = rtag;
        drive_inputs();
        #1;
        snapshot();
        if (!rst_n) begin
            check_val("rst_strobes", 64'(snap_strb), 64'd0);
            check_val("rst_accept", 64'(snap_acc), 64'd0);
            check_val("rst_ack", 64'(snap_ack), 64'd0);
            @(posedge clk);
            #1;
            q.delete();
            lock_m   = -1;
            rr_m     = 0;
            orphan_m = 1'b0;
            return;
        end

        full = (q.size() >= DEPTH);
        gid  = -1;
        if (lock_m >= 0)              gid = lock_m;
        else if (p_act[0] && p_act[1]) gid = rr_m;
        else if (p_act[0])             gid = 0;
        else if (p_act[1])             gid = 1;

        exp_strb   = '0;
        exp_fields = '0;
        exp_ct     = '0;
        if (gid >= 0) begin
            exp_fields = {p_addr[gid], p_data[gid]};
            exp_ct     = {p_cach[gid], p_tag[gid]};
            if (!full) exp_strb = {p_rd[gid], p_wr[gid], p_inv[gid], p_fl[gid]};
        end
        take    = (gid >= 0) && !full && acc;
        exp_acc = '0;
        if (take) exp_acc[gid] = 1'b1;

        owner = -1;
        if (ack && q.size() > 0) owner = q[0];
        for (int i = 0; i < 2; i++) begin
            exp_resp[i]  = (owner == i) ? {1'b1, err, rtag} : 13'd0;
            exp_rdata[i] = (owner == i) ? rdata : 32'd0;
        end

        check_val("mem_strobes", 64'(snap_strb), 64'(exp_strb));
        check_val("mem_addr_data", {mem_addr_o, mem_data_wr_o}, exp_fields);
        check_val("mem_cache_tag", 64'({mem_cacheable_o, mem_req_tag_o}), 64'(exp_ct));
        check_val("accepts", 64'(snap_acc), 64'(exp_acc));
        check_val("m0_resp", 64'({m0_ack_o, m0_error_o, m0_resp_tag_o}), 64'(exp_resp[0]));
        check_val("m0_rdata", 64'(m0_data_rd_o), 64'(exp_rdata[0]));
        check_val("m1_resp", 64'({m1_ack_o, m1_error_o, m1_resp_tag_o}), 64'(exp_resp[1]));
        check_val("m1_rdata", 64'(m1_data_rd_o), 64'(exp_rdata[1]));
        check_val("orphan", 64'(err_orphan_o), 64'(orphan_m));

        if (take)
            $display("[%0t] take m%0d addr=%h tag=%h", $time, gid, p_addr[gid], p_tag[gid]);
        if (owner >= 0)
            $display("[%0t] resp m%0d err=%0d data=%h tag=%h", $time, owner, err, rdata, rtag);

        @(posedge clk);
        #1;
        if (owner >= 0) void'(q.pop_front());
        else if (ack) orphan_m = 1'b1;
        if (take) begin
            q.push_back(gid);
            lock_m = -1;
            rr_m   = 1 - gid;
            p_act[gid] = 1'b0;
            if (auto_refill[gid]) arm_random(gid);
        end else if (gid >= 0) begin
            lock_m = gid;
        end
    endtask

    task automatic idle(input logic acc);
        do_cycle(acc, 1'b0, 1'b0, 32'd0, 11'd0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            p_act[i] = 1'b0;
            auto_refill[i] = 1'b0;
        end
        rst_n = 1'b0;
        idle(1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            p_act[i] = 1'b0; p_rd[i] = 1'b0; p_wr[i] = 4'd0; p_inv[i] = 1'b0; p_fl[i] = 1'b0;
            p_cach[i] = 1'b0; p_addr[i] = 32'd0; p_data[i] = 32'd0; p_tag[i] = 11'd0;
            auto_refill[i] = 1'b0;
        end
        rst_n = 1'b0;
        #2;
        do_reset();
        idle(1'b1);
        check_val("reset_orphan", 64'(snap_orphan), 64'd0);

        // Single read, ack two cycles after the take
        do_reset();
        arm(0, 1'b1, 4'd0, 1'b0, 1'b0, 32'h100, 11'h0A5);
        idle(1'b1);
        check_val("t1_mem_rd", 64'(snap_strb), 64'h40);
        check_val("t1_mem_addr", 64'(snap_addr), 64'h100);
        check_val("t1_accept", 64'(snap_acc), 64'b01);
        idle(1'b1);
        do_cycle(1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 11'h0A5);
        check_val("t1_ack", 64'(snap_ack), 64'b01);
        check_val("t1_data", 64'(snap_m0_data), 64'hDEADBEEF);
        check_val("t1_tag", 64'(snap_m0_tag), 64'h0A5);

        // Continuous contention alternates m0,m1,m0,m1
        do_reset();
        auto_refill[0] = 1'b1;
        auto_refill[1] = 1'b1;
        arm_random(0);
        arm_random(1);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] want;
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            idle(1'b1);
            check_val("t2_rr", 64'(snap_acc), 64'(want));
        end

        // Stalled store keeps the grant against a newly arriving m0
        do_reset();
        arm(1, 1'b0, 4'hF, 1'b0, 1'b0, 32'h200, 11'h011);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) arm(0, 1'b1, 4'd0, 1'b0, 1'b0, 32'h300, 11'h022);
            idle(1'b0);
            check_val("t3_lock_strb", 64'(snap_strb), 64'h3C);
            check_val("t3_no_accept", 64'(snap_acc), 64'd0);
        end
        idle(1'b1);
        check_val("t3_m1_taken", 64'(snap_acc), 64'b10);
        idle(1'b1);
        check_val("t3_m0_taken", 64'(snap_acc), 64'b01);

        // FIFO full blocks requests; a pop frees a slot only for the next cycle
        do_reset();
        auto_refill[0] = 1'b1;
        arm_random(0);
        for (int k = 0; k < 4; k++) idle(1'b1);
        idle(1'b1);
        check_val("t4_full_strb", 64'(snap_strb), 64'd0);
        check_val("t4_full_acc", 64'(snap_acc), 64'd0);
        do_cycle(1'b1, 1'b1, 1'b0, 32'h1234, 11'h001);
        check_val("t4_pop_no_take", 64'(snap_acc), 64'd0);
        check_val("t4_pop_ack", 64'(snap_ack), 64'b01);
        idle(1'b1);
        check_val("t4_take_after", 64'(snap_acc), 64'b01);

        // In-order routing with an error on the middle response
        do_reset();
        arm_random(0);
        arm_random(1);
        idle(1'b1);
        arm_random(0);
        idle(1'b1);
        idle(1'b1);
        do_cycle(1'b0, 1'b1, 1'b0, 32'hA, 11'h1);
        check_val("t5_ack1", 64'(snap_ack), 64'b01);
        do_cycle(1'b0, 1'b1, 1'b1, 32'hB, 11'h2);
        check_val("t5_ack2", 64'(snap_ack), 64'b10);
        check_val("t5_err2", 64'(snap_m1_err), 64'd1);
        do_cycle(1'b0, 1'b1, 1'b0, 32'hC, 11'h3);
        check_val("t5_ack3", 64'(snap_ack), 64'b01);

        // Reset with requests outstanding turns later acks into orphans
        do_reset();
        arm_random(0);
        idle(1'b1);
        arm_random(0);
        idle(1'b1);
        do_reset();
        do_cycle(1'b0, 1'b1, 1'b0, 32'h55, 11'h5);
        check_val("t6_no_ack", 64'(snap_ack), 64'd0);
        idle(1'b0);
        check_val("t6_orphan", 64'(snap_orphan), 64'd1);
        idle(1'b0);
        check_val("t6_orphan_held", 64'(snap_orphan), 64'd1);

        // Random traffic
        do_reset();
        for (int k = 0; k < 400; k++) begin
            logic acc, ack;
            for (int i = 0; i < 2; i++)
                if (!p_act[i] && $urandom_range(0, 1) == 1) arm_random(i);
            acc = ($urandom_range(0, 3) != 0);
            ack = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            do_cycle(acc, ack, 1'($urandom_range(0, 1)), $urandom, 11'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
